// File: rtl/prm_edge_query_seq_if.sv
// Handshake bundle between the edge-query sequencer, the checker bank and the roadmap edge memory.
// master = sequencer side, slave = environment (checker bank, start source, word consumer).
interface prm_edge_query_seq_if #(
  parameter int CODE_W = 15,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  localparam int NB_W = $clog2(WORD_W) + 1;

  logic              start;
  logic [CODE_W-1:0] base_code;
  logic [CNT_W-1:0]  num_edges;
  logic [CODE_W-1:0] query_code;
  logic              query_vld;
  logic              mask_in;
  logic [WORD_W-1:0] out_data;
  logic [NB_W-1:0]   out_nbits;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  hit_count;
  logic              done;

  modport master (
    input  start, base_code, num_edges, mask_in, out_ready,
    output query_code, query_vld, out_data, out_nbits, out_last, out_valid,
           busy, hit_count, done
  );

  modport slave (
    output start, base_code, num_edges, mask_in, out_ready,
    input  query_code, query_vld, out_data, out_nbits, out_last, out_valid,
           busy, hit_count, done
  );
endinterface

// File: rtl/prm_edge_query_seq.sv
// Issues consecutive query codes to the obstacle checker bank, packs the returned edge masks
// LSB-first into words and streams them out on a valid/ready channel with per-run hit count.
module prm_edge_query_seq #(
  parameter int CODE_W  = 15,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16,
  parameter int CHK_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  prm_edge_query_seq_if.master  bus
);
  localparam int NB_W  = $clog2(WORD_W) + 1;
  localparam int IX_W  = $clog2(WORD_W);
  localparam int TAG_W = (CHK_LAT > 0) ? CHK_LAT : 1;
  localparam int SUM_W = NB_W + 1;
  localparam logic [NB_W-1:0]  FULL_CNT = NB_W'(WORD_W);
  localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  packed_q, packed_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [NB_W-1:0]   pack_cnt_q, pack_cnt_d;
  logic              pend_last_q, pend_last_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [NB_W-1:0]   out_nbits_q, out_nbits_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              issue_pre, issue, res_vld, final_now, last_all, out_free;
  logic [WORD_W-1:0] pack_w;
  logic [NB_W-1:0]   cnt_w;
  logic [SUM_W-1:0]  inflight_rem;

  // Valid tags travel alongside the checker latency so mask_in is only sampled for real queries.
  assign tag_d[0] = issue;
  for (genvar gi = 1; gi < TAG_W; gi++) begin : g_tag
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q;
    packed_d    = packed_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    pend_last_d = pend_last_q;
    out_data_d  = out_data_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // With zero latency the result lands in the same cycle, so only the registered fill can gate it.
    issue_pre = (state_q == S_ISSUE) && (issued_q < num_q) &&
                ((CHK_LAT != 0) || (pack_cnt_q < FULL_CNT));
    res_vld   = (CHK_LAT == 0) ? issue_pre : tag_q[TAG_W-1];
    final_now = res_vld && (packed_q == num_q - CNT_W'(1));

    pack_w = pack_q;
    cnt_w  = pack_cnt_q;
    if (res_vld) begin
      pack_w[cnt_w[IX_W-1:0]] = bus.mask_in;
      cnt_w    = cnt_w + NB_W'(1);
      packed_d = packed_q + CNT_W'(1);
      if (bus.mask_in && (hit_q != '1)) begin
        hit_d = hit_q + CNT_W'(1);
      end
    end

    last_all = pend_last_q || final_now;
    out_free = !out_valid_q || bus.out_ready;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (((cnt_w == FULL_CNT) || (last_all && (cnt_w != '0))) && out_free) begin
      out_data_d  = pack_w;
      out_nbits_d = cnt_w;
      out_last_d  = last_all;
      out_valid_d = 1'b1;
      pack_d      = '0;
      pack_cnt_d  = '0;
      pend_last_d = 1'b0;
    end else begin
      pack_d      = pack_w;
      pack_cnt_d  = cnt_w;
      pend_last_d = last_all;
    end

    // Credit: bits left in the pack after this cycle plus results still in the pipe must fit one word.
    inflight_rem = '0;
    for (int i = 0; i < TAG_W - 1; i++) begin
      inflight_rem = inflight_rem + SUM_W'(tag_q[i]);
    end
    issue = issue_pre &&
            ((CHK_LAT == 0) || ((SUM_W'(pack_cnt_d) + inflight_rem) < FULL_SUM));
    if (issue) begin
      issued_d = issued_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d      = bus.base_code;
          num_d       = bus.num_edges;
          issued_d    = '0;
          packed_d    = '0;
          hit_d       = '0;
          pend_last_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (bus.num_edges == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued_d == num_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      packed_q    <= '0;
      tag_q       <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pend_last_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      packed_q    <= packed_d;
      tag_q       <= tag_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      pend_last_q <= pend_last_d;
      out_data_q  <= out_data_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.query_vld  = issue;
  assign bus.query_code = issue ? CODE_W'(base_q + CODE_W'(issued_q)) : '0;
  assign bus.out_data   = out_data_q;
  assign bus.out_nbits  = out_nbits_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.hit_count  = hit_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Drives three sequencers (checker latency 1, 0 and 4) with identical runs against a model checker
// and scoreboards every packed word, query code, hit count and done pulse.
module tb_prm_edge_query_seq;
  localparam int WORD_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_r = 1'b0;
  logic [14:0] base_r  = '0;
  logic [15:0] num_r   = '0;
  logic        out_ready = 1'b1;
  int          mode = 0;
  bit          rnd_tbl [32768];

  typedef struct {
    logic [31:0] data;
    int          nbits;
    bit          last;
  } word_t;

  typedef struct {
    logic [14:0] base;
    int          num;
    int          mode;
    bit          rnd_rdy;
    int          stall;
    int          exp_hits;
  } vec_t;

  word_t q0[$], q1[$], q2[$];
  logic [14:0] run_base = '0;
  int nq[3];
  int done_cnt[3];
  int exp_hits = 0;

  prm_edge_query_seq_if #(.CODE_W(15), .WORD_W(32), .CNT_W(16)) if0 ();
  prm_edge_query_seq_if #(.CODE_W(15), .WORD_W(32), .CNT_W(16)) if1 ();
  prm_edge_query_seq_if #(.CODE_W(15), .WORD_W(32), .CNT_W(16)) if2 ();

  prm_edge_query_seq #(.CODE_W(15), .WORD_W(32), .CNT_W(16), .CHK_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  prm_edge_query_seq #(.CODE_W(15), .WORD_W(32), .CNT_W(16), .CHK_LAT(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  prm_edge_query_seq #(.CODE_W(15), .WORD_W(32), .CNT_W(16), .CHK_LAT(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Model checker: verdict as a pure function of the code, delayed by each instance's latency.
  function automatic logic fm(input logic [14:0] c);
    case (mode)
      0:       return c[0];
      1:       return 1'b1;
      default: return logic'(rnd_tbl[c]);
    endcase
  endfunction

  logic [14:0] p1;
  logic [14:0] p4 [4];
  always @(posedge clk) begin
    p1    <= if0.query_code;
    p4[0] <= if2.query_code;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end

  assign if0.mask_in = fm(p1);
  assign if1.mask_in = fm(if1.query_code);
  assign if2.mask_in = fm(p4[3]);

  assign if0.start = start_r;  assign if0.base_code = base_r;  assign if0.num_edges = num_r;  assign if0.out_ready = out_ready;
  assign if1.start = start_r;  assign if1.base_code = base_r;  assign if1.num_edges = num_r;  assign if1.out_ready = out_ready;
  assign if2.start = start_r;  assign if2.base_code = base_r;  assign if2.num_edges = num_r;  assign if2.out_ready = out_ready;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic qv, input logic [14:0] qc, input logic ov,
                     input logic [31:0] od, input logic [5:0] nb, input logic ol,
                     input logic dn, input logic [15:0] hc);
    word_t w;
    int    sz;
    if (qv) begin
      chk($sformatf("dut%0d_query_code", d), qc, 15'(run_base + 15'(nq[d])));
      nq[d]++;
    end
    if (ov && out_ready) begin
      case (d)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
      chk($sformatf("dut%0d_word_expected", d), sz > 0, 1);
      if (sz > 0) begin
        case (d)
          0:       w = q0.pop_front();
          1:       w = q1.pop_front();
          default: w = q2.pop_front();
        endcase
        $display("WORD dut%0d data=%08h nbits=%0d last=%0d", d, od, nb, ol);
        chk($sformatf("dut%0d_out_data", d), od, w.data);
        chk($sformatf("dut%0d_out_nbits", d), nb, w.nbits);
        chk($sformatf("dut%0d_out_last", d), ol, w.last);
      end
    end
    if (dn) begin
      chk($sformatf("dut%0d_hit_count", d), hc, exp_hits);
      done_cnt[d]++;
    end
  endtask

  always @(negedge clk) if (!rst) mon(0, if0.query_vld, if0.query_code, if0.out_valid, if0.out_data, if0.out_nbits, if0.out_last, if0.done, if0.hit_count);
  always @(negedge clk) if (!rst) mon(1, if1.query_vld, if1.query_code, if1.out_valid, if1.out_data, if1.out_nbits, if1.out_last, if1.done, if1.hit_count);
  always @(negedge clk) if (!rst) mon(2, if2.query_vld, if2.query_code, if2.out_valid, if2.out_data, if2.out_nbits, if2.out_last, if2.done, if2.hit_count);

  // Consumer: optional random ready, or a hold of ready=0 starting at the first word of dut0.
  int          stall_len = 0;
  bit          stall_armed = 1'b0;
  int          stall_left = 0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] hold_data = '0;
  int          nq_at_release = -1;

  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      chk("stall_hold_data", if0.out_data, hold_data);
      chk("stall_hold_valid", if0.out_valid, 1);
      stall_left--;
      if (stall_left == 0) nq_at_release = nq[0];
    end else if (stall_armed && if0.out_valid) begin
      stall_armed = 1'b0;
      stall_left  = stall_len;
      hold_data   = if0.out_data;
    end
    out_ready = (stall_left > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_query_vld"}, if0.query_vld, 0);
    chk({tag, "_query_code"}, if0.query_code, 0);
    chk({tag, "_out_valid"}, if0.out_valid, 0);
    chk({tag, "_out_data"}, if0.out_data, 0);
    chk({tag, "_out_nbits"}, if0.out_nbits, 0);
    chk({tag, "_out_last"}, if0.out_last, 0);
    chk({tag, "_busy"}, if0.busy, 0);
    chk({tag, "_hit_count"}, if0.hit_count, 0);
    chk({tag, "_done"}, if0.done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    word_t       w;
    logic [14:0] c;
    logic        b;
    int          hits;
    int          bitpos;
    int          to;
    mode          = v.mode;
    rnd_rdy       = v.rnd_rdy;
    stall_len     = v.stall;
    stall_armed   = (v.stall > 0);
    nq_at_release = -1;
    run_base      = v.base;
    nq            = '{0, 0, 0};
    done_cnt      = '{0, 0, 0};
    hits   = 0;
    bitpos = 0;
    w.data = '0;
    for (int i = 0; i < v.num; i++) begin
      c = 15'(v.base + 15'(i));
      b = fm(c);
      hits += int'(b);
      w.data[bitpos] = b;
      bitpos++;
      if (bitpos == WORD_W || i == v.num - 1) begin
        w.nbits = bitpos;
        w.last  = (i == v.num - 1);
        q0.push_back(w);
        q1.push_back(w);
        q2.push_back(w);
        w.data = '0;
        bitpos = 0;
      end
    end
    exp_hits = (v.exp_hits >= 0) ? v.exp_hits : hits;
    $display("RUN base=%04h num=%0d mode=%0d exp_hits=%0d", v.base, v.num, v.mode, exp_hits);

    @(posedge clk); #1;
    start_r = 1'b1; base_r = v.base; num_r = 16'(v.num);
    @(posedge clk); #1;
    start_r = 1'b0;
    if (v.num == 0) begin
      @(negedge clk);
      chk("empty_busy_c1", if0.busy, 1);
      chk("empty_done_c1", if0.done, 0);
      @(negedge clk);
      chk("empty_done_c2", if0.done, 1);
      chk("empty_busy_c2", if0.busy, 0);
    end else begin
      for (int k = 0; k < 5 && k < v.num; k++) begin
        @(negedge clk);
        chk("seq_query_vld", if0.query_vld, 1);
        chk("seq_query_code", if0.query_code, 15'(v.base + 15'(k)));
      end
    end
    if (v.num >= 10) begin
      @(posedge clk); #1;
      start_r = 1'b1; base_r = 15'h5555; num_r = 16'd7;
      @(posedge clk); #1;
      start_r = 1'b0;
    end

    to = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1 && done_cnt[2] >= 1) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    chk("done_within_budget", to < 3000, 1);
    repeat (2) @(negedge clk);
    chk("hit_count_held", if0.hit_count, exp_hits);
    chk("busy_after_done", if0.busy, 0);
    chk("single_done_pulse", done_cnt[0], 1);
    chk("dut0_words_left", q0.size(), 0);
    chk("dut1_words_left", q1.size(), 0);
    chk("dut2_words_left", q2.size(), 0);
    chk("dut0_queries", nq[0], v.num);
    chk("dut1_queries", nq[1], v.num);
    chk("dut2_queries", nq[2], v.num);
    if (v.stall > 0 && v.num > 2 * WORD_W) chk("stall_issue_cap", nq_at_release, 2 * WORD_W);
  endtask

  vec_t vecs [11];
  int   to6;

  initial begin
    for (int i = 0; i < 32768; i++) rnd_tbl[i] = 1'($urandom_range(0, 1));
    vecs[0]  = '{15'h0010,   5, 0, 1'b0,  0,  2};
    vecs[1]  = '{15'h7FFE,   4, 0, 1'b0,  0,  2};
    vecs[2]  = '{15'h0000,  70, 1, 1'b0,  0, 70};
    vecs[3]  = '{15'h0100,  64, 2, 1'b0, 20, -1};
    vecs[4]  = '{15'h0200, 100, 2, 1'b0, 40, -1};
    vecs[5]  = '{15'h1234, 100, 2, 1'b0,  0, -1};
    vecs[6]  = '{15'h7FF0,  33, 2, 1'b1,  0, -1};
    vecs[7]  = '{15'h0300,  32, 1, 1'b0,  0, 32};
    vecs[8]  = '{15'h0400,   1, 1, 1'b0,  0,  1};
    vecs[9]  = '{15'h0500,   0, 1, 1'b0,  0,  0};
    vecs[10] = '{15'h4000,  90, 2, 1'b1,  0, -1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset in the middle of a run: everything in flight is dropped.
    mode = 2; rnd_rdy = 1'b0; stall_armed = 1'b0;
    run_base = 15'h0600;
    nq = '{0, 0, 0};
    @(posedge clk); #1;
    start_r = 1'b1; base_r = 15'h0600; num_r = 16'd100;
    @(posedge clk); #1;
    start_r = 1'b0;
    to6 = 0;
    while (nq[0] < 10 && to6 < 100) begin
      @(negedge clk);
      to6++;
    end
    chk("midrun_reached_10", nq[0] >= 10, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("midrun_reset");
    chk("midrun_reset_dut2_busy", if2.busy, 0);
    chk("midrun_reset_dut1_qvld", if1.query_vld, 0);
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    run_vec('{15'h0700, 0, 1, 1'b0, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
